// File: rtl/quad_decoder_if.sv
// rtl/quad_decoder_if.sv - encoder inputs and decoded step outputs of quad_decoder
interface quad_decoder_if;
  logic       a;
  logic       b;
  logic       en;
  logic       ud;
  logic       err;
  logic [1:0] ab_state;

  modport master (output a, b, input en, ud, err, ab_state);
  modport slave  (input a, b, output en, ud, err, ab_state);
endinterface

// File: rtl/quad_decoder.sv
// rtl/quad_decoder.sv - debounced quadrature decoder producing counter en/ud steps and err pulses
module quad_decoder #(
  parameter int DB_CYCLES = 16,
  parameter int PPD       = 4
) (
  input logic            clk,
  input logic            reset,
  quad_decoder_if.slave  qif
);

  localparam int INIT_LEN = DB_CYCLES + 3;
  localparam logic signed [3:0] PPD_S = 4'(PPD);

  typedef enum logic {INIT, RUN} state_t;

  logic [1:0] sync1, sync2, cur, prev, diff;
  logic [7:0] db_cnt [2];
  state_t     state, state_d;
  logic [8:0] init_cnt, init_cnt_d;
  logic signed [3:0] acc, acc_d, step, sum;
  logic       en_q, en_d, err_q, err_d, ud_q, ud_d;

  // Bit 1 is channel A, bit 0 is channel B throughout.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1     <= 2'b00;
      sync2     <= 2'b00;
      cur       <= 2'b00;
      db_cnt[0] <= 8'd0;
      db_cnt[1] <= 8'd0;
    end else begin
      sync1 <= {qif.a, qif.b};
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == cur[i]) begin
          db_cnt[i] <= 8'd0;
        end else if (db_cnt[i] == 8'(DB_CYCLES - 1)) begin
          cur[i]    <= sync2[i];
          db_cnt[i] <= 8'd0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 8'd1;
        end
      end
    end
  end

  assign diff = cur ^ prev;

  always_comb begin
    state_d    = state;
    init_cnt_d = init_cnt;
    acc_d      = acc;
    en_d       = 1'b0;
    err_d      = 1'b0;
    ud_d       = ud_q;
    step       = 4'sd0;
    sum        = acc;
    case (state)
      INIT: begin
        acc_d = 4'sd0;
        if (init_cnt == 9'(INIT_LEN - 1)) state_d = RUN;
        else init_cnt_d = init_cnt + 9'd1;
      end
      default: begin
        if (diff == 2'b11) begin
          err_d = 1'b1;
          acc_d = 4'sd0;
        end else if (diff != 2'b00) begin
          // In up order the new B bit always differs from the old A bit.
          step = (prev[1] ^ cur[0]) ? 4'sd1 : -4'sd1;
          sum  = acc + step;
          if (sum == PPD_S) begin
            en_d  = 1'b1;
            ud_d  = 1'b1;
            acc_d = 4'sd0;
          end else if (sum == -PPD_S) begin
            en_d  = 1'b1;
            ud_d  = 1'b0;
            acc_d = 4'sd0;
          end else begin
            acc_d = sum;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= INIT;
      init_cnt <= 9'd0;
      acc      <= 4'sd0;
      prev     <= 2'b00;
      en_q     <= 1'b0;
      err_q    <= 1'b0;
      ud_q     <= 1'b1;
    end else begin
      state    <= state_d;
      init_cnt <= init_cnt_d;
      acc      <= acc_d;
      prev     <= cur;
      en_q     <= en_d;
      err_q    <= err_d;
      ud_q     <= ud_d;
    end
  end

  assign qif.en       = en_q;
  assign qif.err      = err_q;
  assign qif.ud       = ud_q;
  assign qif.ab_state = cur;

endmodule

// File: tb/tb_quad_decoder.sv
// tb/tb_quad_decoder.sv - directed and random-walk check of quad_decoder against a position model
module tb_quad_decoder;
  localparam int DB  = 4;
  localparam int PPD = 4;
  localparam int LAT = DB + 3;
  localparam int HOLD = 10;

  logic clk = 1'b0;
  logic reset;
  int ncmp = 0;
  int nfail = 0;

  logic [1:0] m_cur;
  int         m_acc;
  logic       m_ud;

  quad_decoder_if qif ();

  quad_decoder #(.DB_CYCLES(DB), .PPD(PPD)) dut (
    .clk   (clk),
    .reset (reset),
    .qif   (qif)
  );

  always #5 clk = ~clk;

  function automatic int pos(logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step_to(logic [1:0] nxt, string tag);
    logic [1:0] old;
    logic exp_en, exp_err, exp_ud, old_ud;
    int d;
    old = m_cur;
    old_ud = m_ud;
    exp_en = 1'b0;
    exp_err = 1'b0;
    exp_ud = m_ud;
    d = (pos(nxt) - pos(old) + 4) % 4;
    if (d == 2) begin
      exp_err = 1'b1;
      m_acc = 0;
    end else if (d != 0) begin
      m_acc += (d == 1) ? 1 : -1;
      if (m_acc == PPD || m_acc == -PPD) begin
        exp_en = 1'b1;
        exp_ud = (m_acc > 0);
        m_acc = 0;
      end
    end
    @(negedge clk);
    qif.a = nxt[1];
    qif.b = nxt[0];
    for (int i = 1; i <= HOLD; i++) begin
      @(negedge clk);
      chk($sformatf("%s.en@%0d", tag, i), 32'(qif.en), 32'((i == LAT) && exp_en));
      chk($sformatf("%s.err@%0d", tag, i), 32'(qif.err), 32'((i == LAT) && exp_err));
      chk($sformatf("%s.ab@%0d", tag, i), 32'(qif.ab_state), 32'((i >= DB + 2) ? nxt : old));
      chk($sformatf("%s.ud@%0d", tag, i), 32'(qif.ud), 32'((i >= LAT) ? exp_ud : old_ud));
    end
    m_cur = nxt;
    m_ud = exp_ud;
  endtask

  task automatic glitch(int bitsel, int len, string tag);
    logic [1:0] g;
    g = m_cur;
    g[bitsel] = ~g[bitsel];
    @(negedge clk);
    qif.a = g[1];
    qif.b = g[0];
    repeat (len) @(negedge clk);
    qif.a = m_cur[1];
    qif.b = m_cur[0];
    for (int i = 1; i <= HOLD; i++) begin
      @(negedge clk);
      chk($sformatf("%s.en@%0d", tag, i), 32'(qif.en), 32'd0);
      chk($sformatf("%s.err@%0d", tag, i), 32'(qif.err), 32'd0);
      chk($sformatf("%s.ab@%0d", tag, i), 32'(qif.ab_state), 32'(m_cur));
    end
  endtask

  task automatic do_reset(logic [1:0] ab, string tag);
    @(negedge clk);
    reset = 1'b1;
    qif.a = ab[1];
    qif.b = ab[0];
    repeat (2) @(negedge clk);
    chk({tag, ".rst_en"}, 32'(qif.en), 32'd0);
    chk({tag, ".rst_err"}, 32'(qif.err), 32'd0);
    chk({tag, ".rst_ud"}, 32'(qif.ud), 32'd1);
    chk({tag, ".rst_ab"}, 32'(qif.ab_state), 32'd0);
    reset = 1'b0;
    for (int i = 1; i <= LAT + 4; i++) begin
      @(negedge clk);
      chk($sformatf("%s.init_en@%0d", tag, i), 32'(qif.en), 32'd0);
      chk($sformatf("%s.init_err@%0d", tag, i), 32'(qif.err), 32'd0);
    end
    chk({tag, ".init_ab"}, 32'(qif.ab_state), 32'(ab));
    m_cur = ab;
    m_acc = 0;
    m_ud = 1'b1;
  endtask

  function automatic logic [1:0] fwd(logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] rev(logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  initial begin
    int r;
    reset = 1'b1;
    qif.a = 1'b0;
    qif.b = 1'b0;
    m_cur = 2'b00;
    m_acc = 0;
    m_ud = 1'b1;

    do_reset(2'b00, "fwd_cycle");
    step_to(2'b01, "fwd1");
    step_to(2'b11, "fwd2");
    step_to(2'b10, "fwd3");
    step_to(2'b00, "fwd4");

    step_to(2'b10, "rev1");
    step_to(2'b11, "rev2");
    step_to(2'b01, "rev3");
    step_to(2'b00, "rev4");

    glitch(1, 3, "glitch_a3");

    step_to(2'b11, "double");
    for (int i = 0; i < 4; i++) step_to(fwd(m_cur), $sformatf("after_err%0d", i));

    for (int i = 0; i < 3; i++) step_to(fwd(m_cur), $sformatf("net_f%0d", i));
    step_to(rev(m_cur), "net_r");
    for (int i = 0; i < 2; i++) step_to(fwd(m_cur), $sformatf("net_g%0d", i));

    do_reset(2'b11, "rst11");
    step_to(fwd(m_cur), "pre_rst0");
    step_to(fwd(m_cur), "pre_rst1");
    do_reset(m_cur, "mid_rst");
    for (int i = 0; i < 4; i++) step_to(fwd(m_cur), $sformatf("post_rst%0d", i));

    for (int n = 0; n < 60; n++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) step_to(~m_cur, $sformatf("rnd%0d_dbl", n));
      else if (r == 1) glitch(int'($urandom_range(0, 1)), int'($urandom_range(1, DB - 1)), $sformatf("rnd%0d_gl", n));
      else if (r <= 4) step_to(rev(m_cur), $sformatf("rnd%0d_rev", n));
      else step_to(fwd(m_cur), $sformatf("rnd%0d_fwd", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 Parameter DB_CYCLES, default 16: consecutive differing samples needed to accept a new level per channel; legal range 1..255.
REQ-002 Parameter PPD, default 4: quadrature sub-steps per emitted count; legal values 1, 2, 4.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 a  input  1  raw encoder channel A, asynchronous to clk.
REQ-006 b  input  1  raw encoder channel B, asynchronous to clk.
REQ-007 en  output  1  one-cycle step pulse; drives a counter's en.
REQ-008 ud  output  1  direction of the last step, 1 = up; drives a counter's ud.
REQ-009 err  output  1  one-cycle pulse on an illegal (double-bit) quadrature transition.
REQ-010 ab_state  output  2  filtered {A,B} state.

Function
REQ-011 Each of a, b SHALL pass through a two-flop synchroniser before any other use.
REQ-012 Each channel SHALL have a debounce counter: cleared whenever the synchronised level equals the filtered level, incremented otherwise.
REQ-013 A filtered level SHALL take the synchronised value on the DB_CYCLES-th consecutive differing sample; its counter clears at that edge.
REQ-014 A differing run shorter than DB_CYCLES SHALL leave the filtered level unchanged.
REQ-015 Decoder SHALL register the previous filtered state prev each cycle and compare it with the current filtered state cur.
REQ-016 Up order SHALL be 00->01->11->10->00; one-bit change in up order = sub-step +1, in reverse order = sub-step -1, cur == prev = no action.
REQ-017 Two-bit change (00<->11, 01<->10) SHALL assert err for one cycle, clear the sub-step accumulator, and not assert en.
REQ-018 Sub-step accumulator SHALL be signed, range -(PPD-1)..+(PPD-1), reset 0.
REQ-019 A +1 sub-step reaching +PPD SHALL assert en for one cycle, set ud=1, clear accumulator.
REQ-020 A -1 sub-step reaching -PPD SHALL assert en for one cycle, set ud=0, clear accumulator.
REQ-021 Otherwise the sub-step SHALL update the accumulator only; direction reversal decrements/increments without error.
REQ-022 en and err are registered, never high in the same cycle, never high in consecutive cycles from one filtered change.
REQ-023 ud SHALL change only in a cycle where en is asserted and holds otherwise.
REQ-024 Latency from the first rising edge sampling a new raw level to en/err high SHALL be DB_CYCLES+3 clocks.
REQ-025 Control FSM states INIT and RUN; INIT counts DB_CYCLES+3 clocks, then goes to RUN.
REQ-026 In INIT, prev tracks cur, accumulator stays 0, en and err stay 0.
REQ-027 ab_state SHALL equal cur at all times.

Reset
REQ-028 With reset high at a rising edge: synchronisers, filtered levels, prev, debounce counters, accumulator = 0; en=0, err=0, ud=1; FSM = INIT.
REQ-029 Reset mid-sequence SHALL discard any partial accumulated sub-steps; reset has priority over every other event.

Verification (DB_CYCLES=4, PPD=4, each raw level held 10 clocks)
REQ-030 Reset, AB 00, then 01,11,10,00 -> exactly one en pulse with ud=1 after the 4th transition, err never high.
REQ-031 From 00: 10,11,01,00 -> exactly one en pulse, ud=0.
REQ-032 AB 00, a high for 3 clocks then low -> ab_state stays 00, no en, no err.
REQ-033 AB 00 -> 11 in one step -> one err pulse, no en; then 4 forward steps needed for the next en.
REQ-034 Forward 3, reverse 1, forward 2 -> no en until the final step (net +4), then one en with ud=1.
REQ-035 AB=11 during reset, release -> no en/err while INIT; ab_state reaches 11; after 2 forward steps assert reset, release, 4 more forward steps -> one en only after the 4th.
